data_memory_ws: RTL
===================

# data_memory_ws

Parametrised, wait-stated data memory for the MEM stage of the ARM pipeline. It accepts one read or write request at a time and completes it after a programmable number of wait states. Completion is signalled with a one-cycle `ready` pulse, so the hazard/freeze logic can stall the pipeline while an access is outstanding. Word-addressed storage sits above a configurable byte base address.

## Interface
- `DATA_WIDTH`, 32: word width in bits.
- `DEPTH`, 64: number of words; must be a power of two, minimum 2.
- `BASE_ADDR`, 1024: byte address of word 0.
- `WAIT_STATES`, 2: extra cycles per access, range 0..15.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `mem_r_en`  in  1  read request.
- `mem_w_en`  in  1  write request.
- `address`  in  32  byte address.
- `wdata`  in  DATA_WIDTH  write data.
- `rdata`  out  DATA_WIDTH  read result; registered.
- `ready`  out  1  one-cycle completion pulse; registered.
- `err`  out  1  out-of-range flag, pulses with `ready`. Present only with `DMEM_RANGE_CHECK_EN`.

## Operation
- Storage: `DEPTH` words; word i holds value i at simulation start. Reset does not alter contents.
- Index: `idx = (address - BASE_ADDR) >> 2`, truncated to log2(DEPTH) bits. Bits [1:0] are ignored.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - A request is `mem_r_en | mem_w_en`.
  - On an edge with a request present, latch `address`, `wdata` and the op. If both enables are high, the op is a write.
  - Go to WAIT with `cnt = WAIT_STATES - 1`, or go straight to DONE if `WAIT_STATES == 0`.
- WAIT: decrement `cnt` each edge. On the edge where `cnt == 0`, go to DONE.
- Entering DONE, using the latched values:
  - Write: `mem[idx] <= wdata`, `rdata <= 0`.
  - Read: `rdata <= mem[idx]`.
  - `ready <= 1`.
- DONE: lasts exactly one cycle. Next edge goes to IDLE with `ready <= 0`. `rdata` holds until the next completion.
- Requests are sampled only in IDLE. The requester must deassert in the cycle `ready` is high, otherwise a new access starts on the following edge.

## Timing
- Reset values: state IDLE, `ready = 0`, `rdata = 0`, `err = 0`, `cnt = 0`.
- Latency: if the request is captured at edge E, `ready` is high in the cycle after edge `E + WAIT_STATES`, i.e. `WAIT_STATES + 1` edges after the request is first seen in IDLE.
- Minimum issue interval is `WAIT_STATES + 2` cycles.
- Inputs may change after the capture edge; latched copies are used.
- Reset asserted in WAIT or DONE:
  - Immediate return to reset values.
  - A pending write is dropped; memory is untouched.
  - A `ready` pulse in progress is cleared asynchronously.

## Configuration
- `DMEM_RANGE_CHECK_EN` defined:
  - An access is out of range if `address < BASE_ADDR` or the untruncated index is `>= DEPTH`.
  - Out-of-range write: suppressed.
  - Out-of-range read: `rdata <= 0`.
  - `err` pulses high together with `ready`.
  - Latency is unchanged.
- `DMEM_RANGE_CHECK_EN` undefined:
  - No `err` port.
  - `address < BASE_ADDR` maps to index 0.
  - Indices above `DEPTH - 1` wrap modulo `DEPTH`.

## Test plan
Default parameters (`WAIT_STATES = 2`, `DEPTH = 64`, `BASE_ADDR = 1024`) unless noted.
- **Read latency:** read `address = 1044` held from reset release → `ready` high exactly 3 edges after capture, `rdata = 5`. Single-cycle pulse; `rdata` stays 5 afterwards.
- **Write then read back:** write `0xDEADBEEF` to 1048, then read 1048 → `rdata = 0xDEADBEEF`. Read 1052 → `rdata = 7`. With `WAIT_STATES = 0`, `ready` follows 1 edge after capture.
- **Simultaneous enables:** `mem_r_en = mem_w_en = 1`, `address = 1024`, `wdata = 0x55` → treated as write; `rdata = 0` at `ready`; a later read of 1024 returns `0x55`.
- **Reset mid-operation:** write `0x1234` to 1028, assert `rst` during WAIT → `ready`, `rdata` go 0 immediately. A later read of 1028 returns 1 (write dropped).
- **Out of range, macro defined:** write `0xFF` to 1280 → `ready = 1`, `err = 1`, no memory word changes. Read 512 → `rdata = 0`, `err = 1`.
- **Out of range, macro undefined:** read 1280 → `rdata = 0` (wraps to index 0). Read 512 → `rdata = 0`. Write `0xAA` to 1284, then read 1028 → `0xAA`.

Source files
------------

// File: rtl/data_memory_ws_if.sv
// Request/response bus between the MEM stage and the wait-stated data memory.
// The err signal exists only when DMEM_RANGE_CHECK_EN is defined.
interface data_memory_ws_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  mem_r_en;
  logic                  mem_w_en;
  logic [31:0]           address;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  ready;
`ifdef DMEM_RANGE_CHECK_EN
  logic                  err;

  modport master (output mem_r_en, mem_w_en, address, wdata,
                  input  rdata, ready, err);
  modport slave  (input  mem_r_en, mem_w_en, address, wdata,
                  output rdata, ready, err);
`else
  modport master (output mem_r_en, mem_w_en, address, wdata,
                  input  rdata, ready);
  modport slave  (input  mem_r_en, mem_w_en, address, wdata,
                  output rdata, ready);
`endif
endinterface

// File: rtl/data_memory_ws.sv
// Wait-stated, word-addressed data memory for the MEM stage; one access at a time.
// Define DMEM_RANGE_CHECK_EN to flag and suppress out-of-range accesses via err.
module data_memory_ws #(
  parameter int          DATA_WIDTH  = 32,
  parameter int          DEPTH       = 64,
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int          WAIT_STATES = 2
) (
  input  logic            clk,
  input  logic            rst,
  data_memory_ws_if.slave bus
);
  localparam int         IDX_W    = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  typedef logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_t;

  function automatic mem_t init_mem();
    for (int i = 0; i < DEPTH; i++) init_mem[i] = DATA_WIDTH'(i);
  endfunction

  // NOTE: storage has no reset; its power-up image comes from the declaration
  // initialiser and only completed in-range writes ever change it.
  mem_t mem = init_mem();

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  op_write_q;
  logic [31:0]           addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  ready_q;
  logic                  capture, finish;

  // NOTE: every always_comb output gets a default first so no path leaves a
  // latch behind.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: if (bus.mem_r_en || bus.mem_w_en) begin
        capture = 1'b1;
        if (WAIT_STATES == 0) begin
          state_d = DONE;
          finish  = 1'b1;
        end else begin
          state_d = WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      WAIT: if (cnt_q == 4'd0) begin
        state_d = DONE;
        finish  = 1'b1;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With no wait states the access completes on its capture edge, so the live
  // bus is used instead of the not-yet-loaded copies.
  logic                  acc_write;
  logic [31:0]           acc_addr;
  logic [DATA_WIDTH-1:0] acc_wdata;
  assign acc_write = (state_q == IDLE) ? bus.mem_w_en : op_write_q;
  assign acc_addr  = (state_q == IDLE) ? bus.address  : addr_q;
  assign acc_wdata = (state_q == IDLE) ? bus.wdata    : wdata_q;

  logic [31:0]      offset;
  logic [29:0]      word_off;
  logic             below_base;
  logic [IDX_W-1:0] idx;
  logic             in_range;
  logic             unused_bits;
  assign offset     = acc_addr - BASE_ADDR;
  assign word_off   = offset[31:2];
  assign below_base = acc_addr < BASE_ADDR;
  assign idx        = below_base ? '0 : word_off[IDX_W-1:0];

`ifdef DMEM_RANGE_CHECK_EN
  logic err_q;
  assign in_range    = !below_base && (word_off < 30'(DEPTH));
  assign unused_bits = ^offset[1:0];
`else
  assign in_range    = 1'b1;
  assign unused_bits = ^{offset[1:0], word_off[29:IDX_W]};
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      op_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      ready_q    <= 1'b0;
`ifdef DMEM_RANGE_CHECK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= finish;
`ifdef DMEM_RANGE_CHECK_EN
      err_q   <= finish && !in_range;
`endif
      if (capture) begin
        op_write_q <= bus.mem_w_en;
        addr_q     <= bus.address;
        wdata_q    <= bus.wdata;
      end
      if (finish) begin
        if (acc_write || !in_range) rdata_q <= '0;
        else                        rdata_q <= mem[idx];
      end
    end
  end

  // The write lands on the edge that enters DONE; a reset during WAIT returns
  // the FSM to IDLE first, so the pending write never reaches the array.
  always_ff @(posedge clk) begin
    if (finish && acc_write && in_range) mem[idx] <= acc_wdata;
  end

  assign bus.rdata = rdata_q;
  assign bus.ready = ready_q;
`ifdef DMEM_RANGE_CHECK_EN
  assign bus.err   = err_q;
`endif
endmodule
